// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller. It holds memory-mapped data and control
// registers and scans one digit per prescaler slot onto two segment buses.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS      = 8,
    parameter int GROUP_SIZE      = 4,
    parameter int DIV_CNT         = 15000,
    parameter bit AN_ACTIVE_HIGH  = 1'b1,
    parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [31:0]           wr_data,
    output logic [7:0]            seg_lo,
    output logic [7:0]            seg_hi,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int CW = $clog2(DIV_CNT);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // XOR masks that turn active-high internal values into the pin polarity
    localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_HIGH ? 8'h00 : 8'hff;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_HIGH ? '0 : '1;

    logic [31:0]           data_q;
    logic [NUM_DIGITS-1:0] dp_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic                  lzs_q;
    logic [CW-1:0]         pre_cnt;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;
    logic                  tick;
    logic [NUM_DIGITS-1:0] zero_from;
    logic [3:0]            nib;
    logic [7:0]            lit;
    logic [7:0]            lo_nxt;
    logic [7:0]            hi_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    function automatic logic [7:0] glyph_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hfc;
            4'h1: return 8'h60;
            4'h2: return 8'hda;
            4'h3: return 8'hf2;
            4'h4: return 8'h66;
            4'h5: return 8'hb6;
            4'h6: return 8'hbe;
            4'h7: return 8'he0;
            4'h8: return 8'hfe;
            4'h9: return 8'hf6;
            4'ha: return 8'hee;
            4'hb: return 8'h3e;
            4'hc: return 8'h9c;
            4'hd: return 8'h7a;
            4'he: return 8'h9e;
            default: return 8'h8e;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            dp_q   <= '0;
            en_q   <= '1;
            lzs_q  <= 1'b0;
        end else if (wr_en) begin
            if (wr_sel) begin
                dp_q  <= wr_data[NUM_DIGITS-1:0];
                en_q  <= wr_data[8 +: NUM_DIGITS];
                lzs_q <= wr_data[16];
            end else begin
                data_q <= wr_data;
            end
        end
    end

    assign tick    = (pre_cnt == CW'(DIV_CNT - 1));
    assign idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + CW'(1);
            if (tick) idx <= idx_nxt;
        end
    end

    // zero_from[i]: every nibble of digit i and above is zero
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        assign zero_from[i] = (data_q[4*NUM_DIGITS-1:4*i] == '0);
    end

    assign nib = data_q[{idx_nxt, 2'b00} +: 4];

    always_comb begin
        lit    = glyph_of(nib);
        an_nxt = '0;
        if (lzs_q && idx_nxt != '0 && zero_from[idx_nxt]) lit = 8'h00;
        lit[0] = lit[0] | dp_q[idx_nxt];
        an_nxt[idx_nxt] = 1'b1;
        if (!en_q[idx_nxt]) begin
            lit    = 8'h00;
            an_nxt = '0;
        end
        lo_nxt = 8'h00;
        hi_nxt = 8'h00;
        if (32'(idx_nxt) < GROUP_SIZE) lo_nxt = lit;
        else                           hi_nxt = lit;
    end

    // Outputs reflect the digit being entered, built from register contents before this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_lo <= SEG_OFF;
            seg_hi <= SEG_OFF;
            an     <= AN_OFF;
        end else if (tick) begin
            seg_lo <= lo_nxt ^ SEG_OFF;
            seg_hi <= hi_nxt ^ SEG_OFF;
            an     <= an_nxt ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with DIV_CNT=4: a reference model queues the
// expected display per slot and a monitor compares both polarity variants every cycle.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  seg_lo, seg_hi, an;
    logic [7:0]  p_lo, p_hi, p_an;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIV_CNT(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .seg_lo(seg_lo), .seg_hi(seg_hi), .an(an)
    );

    seg7_scan_ctrl #(.DIV_CNT(4), .AN_ACTIVE_HIGH(1'b0), .SEG_ACTIVE_HIGH(1'b0)) dut_p (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .seg_lo(p_lo), .seg_hi(p_hi), .an(p_an)
    );

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] an;
    } exp_t;

    logic [7:0] glyph_tab [16] = '{8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66, 8'hb6, 8'hbe, 8'he0,
                                   8'hfe, 8'hf6, 8'hee, 8'h3e, 8'h9c, 8'h7a, 8'h9e, 8'h8e};

    exp_t q[$];
    exp_t cur = '0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference state: register contents, cycles into the current slot, digit on display
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp = 8'h00;
    logic [7:0]  m_en = 8'hff;
    logic        m_lzs = 1'b0;
    int          m_cyc = 0;
    int          m_slot = 0;

    function automatic exp_t expect_digit(int d);
        exp_t       e;
        logic [7:0] g;
        logic [3:0] n;
        e = '0;
        n = m_data[4*d +: 4];
        g = glyph_tab[n];
        if (m_lzs && d > 0 && (m_data >> (4*d)) == 32'd0) g = 8'h00;
        if (m_dp[d]) g = g | 8'h01;
        if (m_en[d]) begin
            if (d < 4) e.lo = g;
            else       e.hi = g;
            e.an = 8'(1 << d);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // reference model: a new digit every 4 clocks, shown from pre-edge register contents
    always begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_data = '0; m_dp = 8'h00; m_en = 8'hff; m_lzs = 1'b0;
            m_cyc = 0; m_slot = 0;
            q.delete();
        end else begin
            if (m_cyc == 3) begin
                m_slot = (m_slot + 1) % 8;
                q.push_back(expect_digit(m_slot));
            end
            m_cyc = (m_cyc + 1) % 4;
            if (wr_en) begin
                if (wr_sel) begin
                    m_dp  = wr_data[7:0];
                    m_en  = wr_data[15:8];
                    m_lzs = wr_data[16];
                end else begin
                    m_data = wr_data;
                end
            end
        end
    end

    // monitor: a queued entry becomes current at the next falling edge and must hold until replaced
    always begin
        @(negedge clk);
        if (!rst) cur = '0;
        else if (q.size() > 0) cur = q.pop_front();
        chk("seg_lo", seg_lo, cur.lo);
        chk("seg_hi", seg_hi, cur.hi);
        chk("an", an, cur.an);
        chk("inv_seg_lo", p_lo, ~cur.lo);
        chk("inv_seg_hi", p_hi, ~cur.hi);
        chk("inv_an", p_an, ~cur.an);
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic sel, input logic [31:0] d);
        @(negedge clk); #1;
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(negedge clk); #1;
        wr_en = 1'b0;
    endtask

    // places the write strobe on the clock edge that is also a slot tick
    task automatic wr_at_tick(input logic sel, input logic [31:0] d);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk); #1;
            if (m_cyc == 3) found = 1'b1;
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL tick_align: no slot tick within 8 cycles");
        end
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(negedge clk); #1;
        wr_en = 1'b0;
    endtask

    initial begin
        bit found;
        run(3); #1 rst = 1'b1;

        wr(1'b0, 32'h12345678);
        run(80);

        wr(1'b0, 32'h0);
        run(5);
        wr_at_tick(1'b0, 32'hffffffff);
        run(12);

        wr(1'b1, 32'h0001_ff00);
        wr(1'b0, 32'h0000_0305);
        run(40);

        wr(1'b1, 32'h0000_0f01);
        wr(1'b0, 32'h0);
        run(40);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) d = d & 32'h0000_00ff;
                if ($urandom_range(0, 1) == 0) wr_at_tick(1'b0, d);
                else                            wr(1'b0, d);
            end else if ($urandom_range(0, 3) == 0) begin
                wr(1'b1, d);
            end else begin
                wr(1'b0, d >> (4 * $urandom_range(0, 7)));
            end
            run($urandom_range(0, 12));
        end

        // reset in the middle of digit 5's slot
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (m_slot == 5 && m_cyc == 2) found = 1'b1;
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL mid_scan_wait: digit 5 not reached");
        end
        @(posedge clk); #1 rst = 1'b0;
        run(3); #1 rst = 1'b1;
        wr(1'b0, 32'h0000_00a0);
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
